// File: rtl/octree_pkg.sv
// Shared definitions for the octree walker: node word layout, response codes,
// walker FSM states and the popcount helper used for child indexing.
package octree_pkg;

  localparam int PTR_MSB    = 31;
  localparam int PTR_LSB    = 16;
  localparam int LEAF_MSB   = 15;
  localparam int LEAF_LSB   = 8;
  localparam int BRANCH_MSB = 7;
  localparam int BRANCH_LSB = 0;

  localparam logic [1:0] ST_MISS   = 2'b00;
  localparam logic [1:0] ST_LEAF   = 2'b01;
  localparam logic [1:0] ST_BRANCH = 2'b10;
  localparam logic [1:0] ST_OVF    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EVAL  = 2'd2,
    RESP  = 2'd3
  } walk_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/octant_child_index.sv
// Decodes one octree node word for a given octant: child address (17-bit, so a
// pointer near the top of the range cannot wrap), leaf/branch hits, overflow.
module octant_child_index
  import octree_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic [31:0] node,
  input  logic [2:0]  k,
  output logic [16:0] child,
  output logic        leaf_hit,
  output logic        branch_hit,
  output logic        overflow
);

  logic [15:0] ptr;
  logic [7:0]  leaf_mask;
  logic [7:0]  branch_mask;
  logic [7:0]  occ;
  logic [7:0]  below_k;
  logic [3:0]  idx;

  assign ptr         = node[PTR_MSB:PTR_LSB];
  assign leaf_mask   = node[LEAF_MSB:LEAF_LSB];
  assign branch_mask = node[BRANCH_MSB:BRANCH_LSB];
  assign occ         = leaf_mask | branch_mask;

  // Children are packed densely: rank of octant k among occupied octants.
  assign below_k = occ & ((8'd1 << k) - 8'd1);
  assign idx     = popcount8(below_k);
  assign child   = {1'b0, ptr} + {13'd0, idx};

  assign leaf_hit   = leaf_mask[k];
  assign branch_hit = branch_mask[k];
  assign overflow   = (child >= 17'(DEPTH)) && (leaf_hit || branch_hit);

endmodule

// File: rtl/octree_node_walker.sv
// Octree node walker: descends the node BRAM from a root along an octant path.
// Build option OCT_WALK_STATS_EN adds saturating node-read and miss counters.
module octree_node_walker
  import octree_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int MAX_DEPTH = 8,
  localparam int ADDRW    = $clog2(DEPTH),
  localparam int LVLW     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [3*MAX_DEPTH-1:0] i_req_path,
  input  logic [LVLW-1:0]        i_req_depth,
  input  logic [ADDRW-1:0]       i_root_addr,
  output logic [ADDRW-1:0]       o_mem_addr_read,
  input  logic [31:0]            i_mem_data,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [1:0]             o_rsp_status,
  output logic [ADDRW-1:0]       o_rsp_addr,
  output logic [LVLW-1:0]        o_rsp_level
`ifdef OCT_WALK_STATS_EN
  ,
  output logic [15:0]            o_stat_reads,
  output logic [15:0]            o_stat_miss
`endif
);

  walk_state_t            state_q, state_d;
  logic [3*MAX_DEPTH-1:0] path_q, path_d;
  logic [LVLW-1:0]        depth_q, depth_d;
  logic [LVLW-1:0]        level_q, level_d;
  logic [ADDRW-1:0]       addr_q, addr_d;
  logic [1:0]             rsp_status_q, rsp_status_d;
  logic [ADDRW-1:0]       rsp_addr_q, rsp_addr_d;
  logic [LVLW-1:0]        rsp_level_q, rsp_level_d;

  logic [LVLW-1:0]        req_depth_clamped;
  logic [LVLW-1:0]        level_inc;
  logic [2:0]             octant;
  logic [16:0]            child;
  logic                   leaf_hit;
  logic                   branch_hit;
  logic                   child_ovf;
  logic                   unused_child_hi;

  assign req_depth_clamped = (i_req_depth > LVLW'(MAX_DEPTH)) ? LVLW'(MAX_DEPTH) : i_req_depth;
  assign level_inc         = level_q + LVLW'(1);
  assign octant            = path_q[3*level_q +: 3];

  octant_child_index #(
    .DEPTH(DEPTH)
  ) u_child_index (
    .node      (i_mem_data),
    .k         (octant),
    .child     (child),
    .leaf_hit  (leaf_hit),
    .branch_hit(branch_hit),
    .overflow  (child_ovf)
  );

  // Upper child bits only matter for the overflow decision made in the decoder.
  assign unused_child_hi = ^child[16:ADDRW];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      path_q       <= '0;
      depth_q      <= '0;
      level_q      <= '0;
      addr_q       <= '0;
      rsp_status_q <= ST_MISS;
      rsp_addr_q   <= '0;
      rsp_level_q  <= '0;
    end else begin
      state_q      <= state_d;
      path_q       <= path_d;
      depth_q      <= depth_d;
      level_q      <= level_d;
      addr_q       <= addr_d;
      rsp_status_q <= rsp_status_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_level_q  <= rsp_level_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    path_d       = path_q;
    depth_d      = depth_q;
    level_d      = level_q;
    addr_d       = addr_q;
    rsp_status_d = rsp_status_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_level_d  = rsp_level_q;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          path_d  = i_req_path;
          depth_d = req_depth_clamped;
          level_d = '0;
          addr_d  = i_root_addr;
          // An empty path resolves to the root itself without touching memory.
          if (req_depth_clamped == '0) begin
            state_d      = RESP;
            rsp_status_d = ST_BRANCH;
            rsp_addr_d   = i_root_addr;
            rsp_level_d  = '0;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        state_d = EVAL;
      end

      EVAL: begin
        if (child_ovf) begin
          state_d      = RESP;
          rsp_status_d = ST_OVF;
          rsp_addr_d   = addr_q;
          rsp_level_d  = level_q;
        end else if (leaf_hit) begin
          state_d      = RESP;
          rsp_status_d = ST_LEAF;
          rsp_addr_d   = child[ADDRW-1:0];
          rsp_level_d  = level_q;
        end else if (branch_hit) begin
          if (level_inc == depth_q) begin
            state_d      = RESP;
            rsp_status_d = ST_BRANCH;
            rsp_addr_d   = child[ADDRW-1:0];
            rsp_level_d  = level_q;
          end else begin
            state_d = FETCH;
            addr_d  = child[ADDRW-1:0];
            level_d = level_inc;
          end
        end else begin
          state_d      = RESP;
          rsp_status_d = ST_MISS;
          rsp_addr_d   = addr_q;
          rsp_level_d  = level_q;
        end
      end

      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_req_ready     = (state_q == IDLE);
  assign o_rsp_valid     = (state_q == RESP);
  assign o_mem_addr_read = addr_q;
  assign o_rsp_status    = rsp_status_q;
  assign o_rsp_addr      = rsp_addr_q;
  assign o_rsp_level     = rsp_level_q;

`ifdef OCT_WALK_STATS_EN
  logic eval_miss;

  assign eval_miss = (state_q == EVAL) && (state_d == RESP) && (rsp_status_d == ST_MISS);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_reads <= '0;
      o_stat_miss  <= '0;
    end else begin
      if ((state_q == EVAL) && (o_stat_reads != 16'hFFFF)) begin
        o_stat_reads <= o_stat_reads + 16'd1;
      end
      if (eval_miss && (o_stat_miss != 16'hFFFF)) begin
        o_stat_miss <= o_stat_miss + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_octree_node_walker.sv
// Scoreboard bench for octree_node_walker: directed requests push expected
// responses; a negedge monitor pops and compares whenever a response appears.
`timescale 1ns/1ps
module tb_octree_node_walker;

  localparam int DEPTH     = 256;
  localparam int MAX_DEPTH = 8;

  logic        i_clk       = 1'b0;
  logic        i_rst_n     = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [23:0] i_req_path  = '0;
  logic [3:0]  i_req_depth = '0;
  logic [7:0]  i_root_addr = '0;
  logic [7:0]  o_mem_addr_read;
  logic [31:0] i_mem_data  = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [1:0]  o_rsp_status;
  logic [7:0]  o_rsp_addr;
  logic [3:0]  o_rsp_level;
`ifdef OCT_WALK_STATS_EN
  logic [15:0] o_stat_reads;
  logic [15:0] o_stat_miss;
`endif

  octree_node_walker #(
    .DEPTH    (DEPTH),
    .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_path     (i_req_path),
    .i_req_depth    (i_req_depth),
    .i_root_addr    (i_root_addr),
    .o_mem_addr_read(o_mem_addr_read),
    .i_mem_data     (i_mem_data),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_status   (o_rsp_status),
    .o_rsp_addr     (o_rsp_addr),
    .o_rsp_level    (o_rsp_level)
`ifdef OCT_WALK_STATS_EN
    ,
    .o_stat_reads   (o_stat_reads),
    .o_stat_miss    (o_stat_miss)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Node memory with one-cycle synchronous read.
  logic [31:0] mem [DEPTH];
  always @(posedge i_clk) i_mem_data <= mem[o_mem_addr_read];

  typedef struct {
    logic [1:0] status;
    logic [7:0] addr;
    logic [3:0] level;
    int         latency;
    logic [7:0] trBase;
    int         trLen;
  } exp_t;

  exp_t expQ [$];
  int   nChecks = 0;
  int   nFail   = 0;

  bit   walking = 1'b0;
  int   lat     = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles since the accepting edge; the accept edge itself counts as 1.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      walking <= 1'b0;
      lat     <= 0;
    end else begin
      if (o_rsp_valid && i_rsp_ready) walking <= 1'b0;
      if (i_req_valid && o_req_ready) begin
        walking <= 1'b1;
        lat     <= 1;
      end else if (walking) begin
        lat <= lat + 1;
      end
    end
  end

  // Monitor: records the distinct read-address sequence and scores responses.
  initial begin
    logic [7:0] tr [9];
    int   ntr;
    bit   responded;
    exp_t e;
    ntr       = 0;
    responded = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (walking && lat == 1) begin
          ntr       = 0;
          responded = 1'b0;
        end
        if (walking && !responded) begin
          if (ntr == 0) begin
            tr[0] = o_mem_addr_read;
            ntr   = 1;
          end else if (tr[ntr-1] != o_mem_addr_read && ntr < 9) begin
            tr[ntr] = o_mem_addr_read;
            ntr++;
          end
        end
        if (o_rsp_valid && !walking) begin
          checkOutput("unexpected_rsp", 1, 0);
        end else if (o_rsp_valid && !responded) begin
          responded = 1'b1;
          if (expQ.size() == 0) begin
            checkOutput("rsp_without_expect", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("rsp_status", o_rsp_status, e.status);
            checkOutput("rsp_addr", o_rsp_addr, e.addr);
            checkOutput("rsp_level", o_rsp_level, e.level);
            checkOutput("rsp_latency", lat, e.latency);
            checkOutput("read_trace_len", ntr, e.trLen);
            for (int i = 0; i < ntr && i < e.trLen; i++) begin
              checkOutput("read_trace", tr[i], e.trBase + i);
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] root, input logic [3:0] depth, input logic [23:0] path,
                               input bit pushExp, input logic [1:0] st, input logic [7:0] addr,
                               input logic [3:0] lvl, input int latency, input logic [7:0] trBase,
                               input int trLen);
    exp_t e;
    int   n;
    n = 0;
    @(negedge i_clk);
    while (!o_req_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) checkOutput("req_ready_timeout", 0, 1);
    if (pushExp) begin
      e.status  = st;
      e.addr    = addr;
      e.level   = lvl;
      e.latency = latency;
      e.trBase  = trBase;
      e.trLen   = trLen;
      expQ.push_back(e);
    end
    i_root_addr = root;
    i_req_depth = depth;
    i_req_path  = path;
    i_req_valid = 1'b1;
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while ((walking || expQ.size() != 0 || !o_req_ready) && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      checkOutput("walk_timeout", 1, 0);
      expQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0001_00_05;
    mem[1]  = 32'h0003_80_00;
    mem[30] = 32'h0020_04_04;
    mem[40] = 32'h0029_00_01;
    mem[41] = 32'h00FF_00_03;
    for (int a = 10; a < 18; a++) mem[a] = {16'(a + 1), 8'h00, 8'h01};

    repeat (3) @(negedge i_clk);
    checkOutput("reset_req_ready", o_req_ready, 1);
    checkOutput("reset_rsp_valid", o_rsp_valid, 0);
    checkOutput("reset_rsp_status", o_rsp_status, 0);
    checkOutput("reset_rsp_addr", o_rsp_addr, 0);
    checkOutput("reset_rsp_level", o_rsp_level, 0);
    checkOutput("reset_mem_addr", o_mem_addr_read, 0);
    i_rst_n = 1'b1;

    // root, depth, path, push, status, addr, level, latency, trace base, trace length
    applyStimulus(8'd0,  4'd2,  24'h000038, 1, 2'b01, 8'd3,   4'd1, 5,  8'd0,  2); waitDone();
    applyStimulus(8'd0,  4'd1,  24'h000001, 1, 2'b00, 8'd0,   4'd0, 3,  8'd0,  1); waitDone();
    applyStimulus(8'd0,  4'd1,  24'h000002, 1, 2'b10, 8'd2,   4'd0, 3,  8'd0,  1); waitDone();
    applyStimulus(8'd5,  4'd0,  24'h000000, 1, 2'b10, 8'd5,   4'd0, 1,  8'd5,  1); waitDone();
    applyStimulus(8'd30, 4'd1,  24'h000002, 1, 2'b01, 8'd32,  4'd0, 3,  8'd30, 1); waitDone();
    applyStimulus(8'd10, 4'd15, 24'h000000, 1, 2'b10, 8'd18,  4'd7, 17, 8'd10, 8); waitDone();
    applyStimulus(8'd40, 4'd2,  24'h000000, 1, 2'b10, 8'd255, 4'd1, 5,  8'd40, 2); waitDone();
    applyStimulus(8'd40, 4'd2,  24'h000008, 1, 2'b11, 8'd41,  4'd1, 5,  8'd40, 2); waitDone();

    // Held response under backpressure.
    i_rsp_ready = 1'b0;
    applyStimulus(8'd0, 4'd2, 24'h000038, 1, 2'b01, 8'd3, 4'd1, 5, 8'd0, 2);
    n = 0;
    while (!o_rsp_valid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) checkOutput("bp_rsp_timeout", 0, 1);
    repeat (10) begin
      @(negedge i_clk);
      checkOutput("bp_rsp_valid", o_rsp_valid, 1);
      checkOutput("bp_rsp_status", o_rsp_status, 2'b01);
      checkOutput("bp_rsp_addr", o_rsp_addr, 3);
      checkOutput("bp_rsp_level", o_rsp_level, 1);
      checkOutput("bp_req_ready", o_req_ready, 0);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    checkOutput("bp_release_valid", o_rsp_valid, 0);
    checkOutput("bp_release_ready", o_req_ready, 1);
    waitDone();

    // Asynchronous reset during the level-1 evaluation discards the walk.
    applyStimulus(8'd0, 4'd2, 24'h000038, 0, 2'b00, 8'd0, 4'd0, 0, 8'd0, 0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkOutput("arst_rsp_valid", o_rsp_valid, 0);
    checkOutput("arst_req_ready", o_req_ready, 1);
    checkOutput("arst_mem_addr", o_mem_addr_read, 0);
    checkOutput("arst_rsp_status", o_rsp_status, 0);
    checkOutput("arst_rsp_addr", o_rsp_addr, 0);
    checkOutput("arst_rsp_level", o_rsp_level, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      checkOutput("post_arst_no_rsp", o_rsp_valid, 0);
    end
    applyStimulus(8'd0, 4'd1, 24'h000001, 1, 2'b00, 8'd0, 4'd0, 3, 8'd0, 1); waitDone();

    // Child pointer beyond the memory.
    mem[0] = 32'hFFFF_00_01;
    applyStimulus(8'd0, 4'd1, 24'h000000, 1, 2'b11, 8'd0, 4'd0, 3, 8'd0, 1); waitDone();

    repeat (3) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
